// File: rtl/ctrl_pkg.sv
// Shared definitions for the TSC multicycle control unit: opcode/function
// encodings, ALU operation codes, datapath mux selects, FSM state encoding
// and the decoded-instruction payload structs.
package ctrl_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SEL_W    = 2;

    // Opcodes (instruction bits [WORD_W-1 -: 4])
    localparam logic [OP_W-1:0] OP_BNE = 4'd0;
    localparam logic [OP_W-1:0] OP_BEQ = 4'd1;
    localparam logic [OP_W-1:0] OP_BGZ = 4'd2;
    localparam logic [OP_W-1:0] OP_BLZ = 4'd3;
    localparam logic [OP_W-1:0] OP_ADI = 4'd4;
    localparam logic [OP_W-1:0] OP_ORI = 4'd5;
    localparam logic [OP_W-1:0] OP_LHI = 4'd6;
    localparam logic [OP_W-1:0] OP_LWD = 4'd7;
    localparam logic [OP_W-1:0] OP_SWD = 4'd8;
    localparam logic [OP_W-1:0] OP_JMP = 4'd9;
    localparam logic [OP_W-1:0] OP_JAL = 4'd10;
    localparam logic [OP_W-1:0] OP_R   = 4'd15;

    // Function codes for OP_R (instruction bits [5:0])
    localparam logic [FUNC_W-1:0] FUNC_ADD = 6'd0;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 6'd1;
    localparam logic [FUNC_W-1:0] FUNC_AND = 6'd2;
    localparam logic [FUNC_W-1:0] FUNC_ORR = 6'd3;
    localparam logic [FUNC_W-1:0] FUNC_NOT = 6'd4;
    localparam logic [FUNC_W-1:0] FUNC_TCP = 6'd5;
    localparam logic [FUNC_W-1:0] FUNC_SHL = 6'd6;
    localparam logic [FUNC_W-1:0] FUNC_SHR = 6'd7;
    localparam logic [FUNC_W-1:0] FUNC_JPR = 6'd25;
    localparam logic [FUNC_W-1:0] FUNC_JRL = 6'd26;
    localparam logic [FUNC_W-1:0] FUNC_WWD = 6'd28;
    localparam logic [FUNC_W-1:0] FUNC_HLT = 6'd29;

    // ALU operation codes; two's complement is NOT with carry-in set
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'd7;

    // PC source select
    localparam logic [SEL_W-1:0] PC_SRC_SEQ = 2'd0;  // PC+1
    localparam logic [SEL_W-1:0] PC_SRC_BR  = 2'd1;  // PC+1+imm
    localparam logic [SEL_W-1:0] PC_SRC_JMP = 2'd2;  // {PC[15:12], imm12}
    localparam logic [SEL_W-1:0] PC_SRC_REG = 2'd3;  // rs

    // Register-file destination select
    localparam logic [SEL_W-1:0] REG_DST_RT   = 2'd0;
    localparam logic [SEL_W-1:0] REG_DST_RD   = 2'd1;
    localparam logic [SEL_W-1:0] REG_DST_LINK = 2'd2;

    // Write-back data select
    localparam logic [SEL_W-1:0] M2R_MEM = 2'd0;
    localparam logic [SEL_W-1:0] M2R_ALU = 2'd1;
    localparam logic [SEL_W-1:0] M2R_PC1 = 2'd2;

    // ALU operand selects (operand B code 3 = constant 1, unused by this FSM)
    localparam logic [SEL_W-1:0] SRC_A_RS   = 2'd0;
    localparam logic [SEL_W-1:0] SRC_A_ZERO = 2'd1;
    localparam logic [SEL_W-1:0] SRC_B_RT   = 2'd0;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'd1;
    localparam logic [SEL_W-1:0] SRC_B_LHI  = 2'd2;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // Instruction class flags; exactly one of the primary classes is set
    typedef struct packed {
        logic r_alu;
        logic imm;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jump_reg;   // jump target comes from rs (JPR/JRL)
        logic link;       // jump also writes PC+1 to the link register
        logic wwd;
        logic hlt;
        logic illegal;
    } inst_class_t;

    // ALU controls used in EX (and held through MEM for address generation)
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [SEL_W-1:0]    src_a;
        logic [SEL_W-1:0]    src_b;
        logic                carry;
    } ex_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder for the multicycle control unit.
// Ports:
//   ir        in   WORD_W  latched instruction register
//   cls_c     out  struct  instruction class flags
//   ex_c      out  struct  ALU op / operand selects / carry for EX
//   bcond_c   out  2       branch condition (op[1:0])
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic [WORD_W-1:0] ir,
    output inst_class_t       cls_c,
    output ex_ctrl_t          ex_c,
    output logic [1:0]        bcond_c
);

    logic [OP_W-1:0]   op;
    logic [FUNC_W-1:0] func;
    logic              unused_ir_bits;

    assign op             = ir[WORD_W-1 -: OP_W];
    assign func           = ir[FUNC_W-1:0];
    assign bcond_c        = op[1:0];
    // Register/immediate fields are consumed by the datapath, not here
    assign unused_ir_bits = ^ir[WORD_W-OP_W-1:FUNC_W];

    // Class and EX-stage control decode
    always_comb begin
        cls_c = '0;
        ex_c  = '0;
        case (op)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls_c.branch = 1'b1;
            OP_ADI: begin
                cls_c.imm    = 1'b1;
                ex_c.alu_op  = ALU_ADD;
                ex_c.src_a   = SRC_A_RS;
                ex_c.src_b   = SRC_B_IMM;
            end
            OP_ORI: begin
                cls_c.imm    = 1'b1;
                ex_c.alu_op  = ALU_OR;
                ex_c.src_a   = SRC_A_RS;
                ex_c.src_b   = SRC_B_IMM;
            end
            OP_LHI: begin
                // imm<<8 OR zero
                cls_c.imm    = 1'b1;
                ex_c.alu_op  = ALU_OR;
                ex_c.src_a   = SRC_A_ZERO;
                ex_c.src_b   = SRC_B_LHI;
            end
            OP_LWD, OP_SWD: begin
                cls_c.load   = (op == OP_LWD);
                cls_c.store  = (op == OP_SWD);
                ex_c.alu_op  = ALU_ADD;
                ex_c.src_a   = SRC_A_RS;
                ex_c.src_b   = SRC_B_IMM;
            end
            OP_JMP: cls_c.jump = 1'b1;
            OP_JAL: begin
                cls_c.jump = 1'b1;
                cls_c.link = 1'b1;
            end
            OP_R: begin
                ex_c.src_a = SRC_A_RS;
                ex_c.src_b = SRC_B_RT;
                case (func)
                    FUNC_ADD: begin cls_c.r_alu = 1'b1; ex_c.alu_op = ALU_ADD; end
                    FUNC_SUB: begin cls_c.r_alu = 1'b1; ex_c.alu_op = ALU_SUB; end
                    FUNC_AND: begin cls_c.r_alu = 1'b1; ex_c.alu_op = ALU_AND; end
                    FUNC_ORR: begin cls_c.r_alu = 1'b1; ex_c.alu_op = ALU_OR;  end
                    FUNC_NOT: begin cls_c.r_alu = 1'b1; ex_c.alu_op = ALU_NOT; end
                    FUNC_TCP: begin
                        cls_c.r_alu = 1'b1;
                        ex_c.alu_op = ALU_NOT;
                        ex_c.carry  = 1'b1;
                    end
                    FUNC_SHL: begin cls_c.r_alu = 1'b1; ex_c.alu_op = ALU_SHL; end
                    FUNC_SHR: begin cls_c.r_alu = 1'b1; ex_c.alu_op = ALU_SHR; end
                    FUNC_JPR: begin
                        cls_c.jump     = 1'b1;
                        cls_c.jump_reg = 1'b1;
                    end
                    FUNC_JRL: begin
                        cls_c.jump     = 1'b1;
                        cls_c.jump_reg = 1'b1;
                        cls_c.link     = 1'b1;
                    end
                    FUNC_WWD: cls_c.wwd     = 1'b1;
                    FUNC_HLT: cls_c.hlt     = 1'b1;
                    default:  cls_c.illegal = 1'b1;
                endcase
            end
            default: cls_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control FSM for the 16-bit TSC datapath (IF/ID/EX/MEM/WB/HALT).
// Latches the instruction register, drives datapath mux selects, ALU
// controls, register-file and PC strobes, and a variable-latency memory
// request held until mem_ready. Counts retired instructions.
// Optional: define CTRL_PERF_CNT_EN to build the cycle and stall counters;
// otherwise cycle_cnt/stall_cnt are tied to zero.
// Ports:
//   clk, reset (async, active-high)
//   inst, mem_ready, branch_taken                      inputs
//   mem_req, mem_write, mem_addr_sel, ir_write         memory / IR controls
//   pc_write, pc_src, bcond                            PC controls
//   reg_write, reg_dst, mem_to_reg                     register-file controls
//   alu_src_a, alu_src_b, alu_op, alu_carry            ALU controls
//   wwd, halted, num_inst, cycle_cnt, stall_cnt        status
module multicycle_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   inst,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                mem_req,
    output logic                mem_write,
    output logic                mem_addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic [SEL_W-1:0]    pc_src,
    output logic [1:0]          bcond,
    output logic                reg_write,
    output logic [SEL_W-1:0]    reg_dst,
    output logic [SEL_W-1:0]    mem_to_reg,
    output logic [SEL_W-1:0]    alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_carry,
    output logic                wwd,
    output logic                halted,
    output logic [CNT_W-1:0]    num_inst,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] ir;
    inst_class_t       cls_c;
    ex_ctrl_t          ex_c;
    logic [1:0]        bcond_c;
    logic              retire_c;

    ctrl_decode #(
        .WORD_W (WORD_W)
    ) u_decode (
        .ir      (ir),
        .cls_c   (cls_c),
        .ex_c    (ex_c),
        .bcond_c (bcond_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IF;
        else       state <= state_nxt;
    end

    // Instruction register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         ir <= '0;
        else if (ir_write) ir <= inst;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IF:  if (mem_ready) state_nxt = S_ID;
            S_ID: begin
                if (cls_c.r_alu || cls_c.imm || cls_c.load || cls_c.store)
                    state_nxt = S_EX;
                else if (cls_c.hlt)
                    state_nxt = S_HALT;
                else
                    state_nxt = S_IF;
            end
            S_EX:  state_nxt = (cls_c.load || cls_c.store) ? S_MEM : S_WB;
            S_MEM: if (mem_ready) state_nxt = cls_c.load ? S_WB : S_IF;
            S_WB:  state_nxt = S_IF;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase
    end

    // Output logic; everything is forced low while reset is held so an
    // aborted instruction cannot issue a write.
    always_comb begin
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_SEQ;
        bcond        = 2'd0;
        reg_write    = 1'b0;
        reg_dst      = REG_DST_RT;
        mem_to_reg   = M2R_MEM;
        alu_src_a    = SRC_A_RS;
        alu_src_b    = SRC_B_RT;
        alu_op       = ALU_ADD;
        alu_carry    = 1'b0;
        wwd          = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            case (state)
                S_IF: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b0;
                    ir_write     = mem_ready;
                end
                S_ID: begin
                    if (cls_c.branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_SRC_BR : PC_SRC_SEQ;
                        bcond    = bcond_c;
                    end else if (cls_c.jump) begin
                        pc_write = 1'b1;
                        pc_src   = cls_c.jump_reg ? PC_SRC_REG : PC_SRC_JMP;
                        if (cls_c.link) begin
                            reg_write  = 1'b1;
                            reg_dst    = REG_DST_LINK;
                            mem_to_reg = M2R_PC1;
                        end
                    end else if (cls_c.wwd) begin
                        wwd      = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_SEQ;
                    end else if (cls_c.illegal) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_SEQ;
                    end
                end
                S_EX: begin
                    alu_op    = ex_c.alu_op;
                    alu_src_a = ex_c.src_a;
                    alu_src_b = ex_c.src_b;
                    alu_carry = ex_c.carry;
                end
                S_MEM: begin
                    // ALU controls held so the address stays stable while waiting
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_write    = cls_c.store;
                    alu_op       = ex_c.alu_op;
                    alu_src_a    = ex_c.src_a;
                    alu_src_b    = ex_c.src_b;
                    if (cls_c.store && mem_ready) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_SEQ;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = PC_SRC_SEQ;
                    if (cls_c.r_alu) begin
                        reg_dst    = REG_DST_RD;
                        mem_to_reg = M2R_ALU;
                    end else if (cls_c.imm) begin
                        reg_dst    = REG_DST_RT;
                        mem_to_reg = M2R_ALU;
                    end else begin
                        reg_dst    = REG_DST_RT;
                        mem_to_reg = M2R_MEM;
                    end
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    // An instruction retires when control returns to IF, or on halting
    assign retire_c = ((state == S_ID || state == S_MEM || state == S_WB) &&
                       state_nxt == S_IF) ||
                      (state != S_HALT && state_nxt == S_HALT);

    // Retired-instruction counter (wraps)
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         num_inst <= '0;
        else if (retire_c) num_inst <= num_inst + CNT_W'(1);
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] stall_q;

    // Performance counters: active cycles and memory wait cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            if (state != S_HALT)
                cycle_q <= cycle_q + CNT_W'(1);
            if ((state == S_IF || state == S_MEM) && !mem_ready)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
